flu_offset_attach: RTL

FLU_OFFSET_ATTACH -- requirements
Module: flu_offset_attach

---
 rtl/flu_offset_attach.sv | 131 +++++++++++++
 1 files changed

// File: rtl/flu_offset_attach.sv
// Single register stage on an FLU stream that binds one per-frame extraction offset to every
// output word and raises a sticky flag on malformed SOP/EOP sequences.
module flu_offset_attach #(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned SOP_POS_WIDTH = 3,
  parameter int unsigned OFFSET_WIDTH  = 10
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [DATA_WIDTH-1:0]             RX_DATA,
  input  logic [SOP_POS_WIDTH-1:0]          RX_SOP_POS,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   RX_EOP_POS,
  input  logic                              RX_SOP,
  input  logic                              RX_EOP,
  input  logic                              RX_SRC_RDY,
  output logic                              RX_DST_RDY,
  input  logic [OFFSET_WIDTH-1:0]           OFF_DATA,
  input  logic                              OFF_SRC_RDY,
  output logic                              OFF_DST_RDY,
  output logic [DATA_WIDTH-1:0]             TX_DATA,
  output logic [SOP_POS_WIDTH-1:0]          TX_SOP_POS,
  output logic [$clog2(DATA_WIDTH/8)-1:0]   TX_EOP_POS,
  output logic                              TX_SOP,
  output logic                              TX_EOP,
  output logic                              TX_SRC_RDY,
  input  logic                              TX_DST_RDY,
  output logic [OFFSET_WIDTH-1:0]           TX_OFFSET,
  output logic                              ERR
);

  localparam int unsigned EopW       = $clog2(DATA_WIDTH / 8);
  localparam int unsigned BlockBytes = DATA_WIDTH / 8 / (2 ** SOP_POS_WIDTH);
  // One guard bit so the SOP byte index never wraps before the compare.
  localparam int unsigned IdxW       = EopW + 1;

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StInFrame = 1'b1;

  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [SOP_POS_WIDTH-1:0] sop_pos_q;
  logic [EopW-1:0]          eop_pos_q;
  logic                     sop_q;
  logic                     eop_q;
  logic [OFFSET_WIDTH-1:0]  tx_off_q;
  logic [OFFSET_WIDTH-1:0]  cur_off_q;
  logic [0:0]               state_q;
  logic [0:0]               state_d;
  logic                     err_q;
  logic                     err_d;
  logic                     rx_rdy;
  logic                     rx_acc;
  logic [IdxW-1:0]          s_idx;
  logic [IdxW-1:0]          e_idx;

  always_comb begin
    rx_rdy = RESET & (~valid_q | TX_DST_RDY) & (~RX_SOP | OFF_SRC_RDY);
    rx_acc = RX_SRC_RDY & rx_rdy;
    s_idx  = IdxW'(RX_SOP_POS) * IdxW'(BlockBytes);
    e_idx  = IdxW'(RX_EOP_POS);
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (rx_acc) begin
      case ({RX_SOP, RX_EOP})
        2'b10:   state_d = StInFrame;
        2'b01:   state_d = StIdle;
        // Both markers: SOP after EOP means the word closes one frame and opens the next.
        2'b11:   state_d = (s_idx > e_idx) ? StInFrame : StIdle;
        default: state_d = state_q;
      endcase
      if (state_q == StInFrame) begin
        if (RX_SOP && !(RX_EOP && (e_idx < s_idx))) err_d = 1'b1;
      end else begin
        if (RX_EOP && !(RX_SOP && (s_idx <= e_idx))) err_d = 1'b1;
        if (!RX_SOP && !RX_EOP) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q   <= 1'b0;
      state_q   <= StIdle;
      err_q     <= 1'b0;
      cur_off_q <= '0;
      tx_off_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (rx_acc) begin
        valid_q <= 1'b1;
        if (RX_SOP) begin
          cur_off_q <= OFF_DATA;
          tx_off_q  <= OFF_DATA;
        end else begin
          tx_off_q  <= cur_off_q;
        end
      end else if (TX_DST_RDY) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Payload fields need no reset; they are qualified by TX_SRC_RDY.
  always_ff @(posedge CLK) begin
    if (rx_acc) begin
      data_q    <= RX_DATA;
      sop_pos_q <= RX_SOP_POS;
      eop_pos_q <= RX_EOP_POS;
      sop_q     <= RX_SOP;
      eop_q     <= RX_EOP;
    end
  end

  always_comb begin
    RX_DST_RDY  = rx_rdy;
    OFF_DST_RDY = rx_acc & RX_SOP;
    TX_DATA     = data_q;
    TX_SOP_POS  = sop_pos_q;
    TX_EOP_POS  = eop_pos_q;
    TX_SOP      = sop_q;
    TX_EOP      = eop_q;
    TX_SRC_RDY  = valid_q & RESET;
    TX_OFFSET   = {OFFSET_WIDTH{RESET}} & tx_off_q;
    ERR         = err_q & RESET;
  end

endmodule
